// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle between a single-beat initiator and a register-block slave port.
interface axi_lite_master_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int C_M_AXI_DATA_WIDTH = 32
);
    // Write address channel
    logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR;
    logic [2:0]                        M_AXI_AWPROT;
    logic                              M_AXI_AWVALID;
    logic                              M_AXI_AWREADY;
    // Write data channel
    logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB;
    logic                              M_AXI_WVALID;
    logic                              M_AXI_WREADY;
    // Write response channel
    logic [1:0]                        M_AXI_BRESP;
    logic                              M_AXI_BVALID;
    logic                              M_AXI_BREADY;
    // Read address channel
    logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR;
    logic [2:0]                        M_AXI_ARPROT;
    logic                              M_AXI_ARVALID;
    logic                              M_AXI_ARREADY;
    // Read data channel
    logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA;
    logic [1:0]                        M_AXI_RRESP;
    logic                              M_AXI_RVALID;
    logic                              M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-beat AXI4-Lite initiator: one read or write at a time from a command port,
// with a per-transaction timeout so a hung slave cannot wedge the command side.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AWVALID/WVALID outstanding, each drops on its own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_RESP | RREADY high, waiting for RVALID
// DONE    | rsp_valid high for this single cycle
module axi_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    axi_lite_master_if.master               m_axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int        STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;
    localparam bit        TMO_EN     = (C_TIMEOUT_CYCLES != 0);
    // Abort fires on the edge where the cycle count would reach the limit.
    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]           wstrb_q, wstrb_d;
    logic                            write_q, write_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                      resp_q, resp_d;
    logic                            timeout_q, timeout_d;
    logic [15:0]                     cnt_q, cnt_d;

    logic busy;
    logic aw_done;
    logic w_done;
    logic timeout_hit;

    assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_RESP);

    // A channel counts as done if it already handshook or handshakes this edge.
    assign aw_done = !awvalid_q || m_axi.M_AXI_AWREADY;
    assign w_done  = !wvalid_q  || m_axi.M_AXI_WREADY;

    assign timeout_hit = TMO_EN && busy && (cnt_q == TMO_LAST);

    // Command port is open only in IDLE and never while reset is held.
    assign cmd_ready = (state_q == IDLE) && !rst;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;

    // Next-state and next-output decode; abort overrides any in-flight progress.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        timeout_d   = timeout_q;
        cnt_d       = busy ? (cnt_q + 16'd1) : cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    cnt_d     = '0;
                    rdata_d   = '0;
                    resp_d    = 2'b00;
                    timeout_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi.M_AXI_BVALID) begin
                    resp_d      = m_axi.M_AXI_BRESP;
                    bready_d    = 1'b0;
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                end
            end
            RD_REQ: begin
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi.M_AXI_RVALID) begin
                    rdata_d     = m_axi.M_AXI_RDATA;
                    resp_d      = m_axi.M_AXI_RRESP;
                    rready_d    = 1'b0;
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A genuine response on the limit edge is kept; otherwise the slave is abandoned.
        if (timeout_hit && (state_d != DONE)) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rdata_d     = '0;
            resp_d      = RESP_SLVERR;
            timeout_d   = 1'b1;
            state_d     = DONE;
            rsp_valid_d = 1'b1;
        end
    end

    // State and registered outputs; reset drops every handshake immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= 2'b00;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench: stimulus pushes the expected response of each command, a
// monitor pops and compares on every rsp_valid and polices the bus payload.
module tb_axi_lite_master;
    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int TMO  = 16;
    localparam int HANG = 1000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_write = 1'b0;
    logic [AW-1:0]   cmd_addr  = '0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic [3:0]      cmd_wstrb = '0;
    logic            cmd_ready;
    logic            rsp_valid;
    logic            rsp_write;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_timeout;

    axi_lite_master_if #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) bus ();

    axi_lite_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave responder with programmable wait cycles ----------------
    int d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
    logic [1:0]  t_resp  = 2'b00;
    logic [31:0] t_rdata = '0;
    logic s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0, s_arready = 1'b0, s_rvalid = 1'b0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = '0;
    int k_aw = 0, k_w = 0, k_b = 0, k_ar = 0, k_r = 0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

    assign bus.M_AXI_AWREADY = s_awready;
    assign bus.M_AXI_WREADY  = s_wready;
    assign bus.M_AXI_BVALID  = s_bvalid;
    assign bus.M_AXI_BRESP   = s_bresp;
    assign bus.M_AXI_ARREADY = s_arready;
    assign bus.M_AXI_RVALID  = s_rvalid;
    assign bus.M_AXI_RRESP   = s_rresp;
    assign bus.M_AXI_RDATA   = s_rdata;

    always @(negedge clk) begin
        if (bus.M_AXI_AWVALID) begin
            if (!s_awready) begin
                if (k_aw >= d_aw) begin s_awready <= 1'b1; n_aw <= n_aw + 1; end
                else k_aw <= k_aw + 1;
            end
        end else begin s_awready <= 1'b0; k_aw <= 0; end

        if (bus.M_AXI_WVALID) begin
            if (!s_wready) begin
                if (k_w >= d_w) begin s_wready <= 1'b1; n_w <= n_w + 1; end
                else k_w <= k_w + 1;
            end
        end else begin s_wready <= 1'b0; k_w <= 0; end

        if (bus.M_AXI_BREADY) begin
            if (!s_bvalid) begin
                if (k_b >= d_b) begin s_bvalid <= 1'b1; s_bresp <= t_resp; n_b <= n_b + 1; end
                else k_b <= k_b + 1;
            end
        end else begin s_bvalid <= 1'b0; k_b <= 0; end

        if (bus.M_AXI_ARVALID) begin
            if (!s_arready) begin
                if (k_ar >= d_ar) begin s_arready <= 1'b1; n_ar <= n_ar + 1; end
                else k_ar <= k_ar + 1;
            end
        end else begin s_arready <= 1'b0; k_ar <= 0; end

        if (bus.M_AXI_RREADY) begin
            if (!s_rvalid) begin
                if (k_r >= d_r) begin
                    s_rvalid <= 1'b1; s_rdata <= t_rdata; s_rresp <= t_resp; n_r <= n_r + 1;
                end else k_r <= k_r + 1;
            end
        end else begin s_rvalid <= 1'b0; k_r <= 0; end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          tmo;
        int          lat;
        int          acc;
        int          aw0, w0, b0, ar0, r0, br0;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int rsp_cnt = 0;
    int last_rsp_cyc = 0;
    int n_brise = 0;
    logic [AW-1:0] cur_addr  = '0;
    logic [31:0]   cur_wdata = '0;
    logic [3:0]    cur_wstrb = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail_bound(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no event want event within bound", nm);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one command and wait (bounded) for its response to be consumed by the monitor.
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int aw, input int w, input int b,
                         input int ar, input int r, input logic [1:0] resp,
                         input logic [31:0] rd, input bit hold, input bit gap);
        exp_t e;
        int   i;
        int   start;
        bit   tmo;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        i = 0;
        while (!cmd_ready) begin
            if (i >= 40) begin fail_bound("cmd_accept"); cmd_valid = 1'b0; return; end
            i++;
            tick();
        end
        d_aw = aw; d_w = w; d_b = b; d_ar = ar; d_r = r; t_resp = resp; t_rdata = rd;
        cur_addr = a; cur_wdata = d; cur_wstrb = s;
        tmo = wr ? (aw >= HANG || w >= HANG || b >= HANG) : (ar >= HANG || r >= HANG);
        e.wr    = wr;
        e.tmo   = tmo;
        e.resp  = tmo ? 2'b10 : resp;
        e.rdata = (tmo || wr) ? 32'h0 : rd;
        e.lat   = tmo ? TMO + 1 : (wr ? 3 + ((aw > w) ? aw : w) + b : 3 + ar + r);
        e.acc   = cyc + 1;
        e.aw0 = n_aw; e.w0 = n_w; e.b0 = n_b; e.ar0 = n_ar; e.r0 = n_r; e.br0 = n_brise;
        if (gap) chk("accept_gap", 32'(e.acc - last_rsp_cyc), 32'd2);
        sb.push_back(e);
        start = rsp_cnt;
        tick();
        if (!hold) cmd_valid = 1'b0;
        i = 0;
        while (rsp_cnt == start) begin
            if (i >= 60) begin fail_bound("rsp_wait"); break; end
            if (hold) begin cmd_addr = AW'($urandom); cmd_wdata = $urandom; end
            i++;
            tick();
        end
    endtask

    logic prev_bready = 1'b0;

    initial begin
        fork
            // monitor
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (bus.M_AXI_BREADY && !prev_bready) n_brise++;
                        prev_bready = bus.M_AXI_BREADY;
                        if (bus.M_AXI_AWVALID) chk("awaddr_stable", 32'(bus.M_AXI_AWADDR), 32'(cur_addr));
                        if (bus.M_AXI_WVALID) begin
                            chk("wdata_stable", bus.M_AXI_WDATA, cur_wdata);
                            chk("wstrb_stable", 32'(bus.M_AXI_WSTRB), 32'(cur_wstrb));
                        end
                        if (bus.M_AXI_ARVALID) chk("araddr_stable", 32'(bus.M_AXI_ARADDR), 32'(cur_addr));
                        if (rsp_valid) begin
                            if (sb.size() == 0) begin
                                total++; bad++;
                                $display("FAIL unexpected_rsp: got rsp_valid want none");
                            end else begin
                                e = sb.pop_front();
                                chk("rsp_write", 32'(rsp_write), 32'(e.wr));
                                chk("rsp_rdata", rsp_rdata, e.rdata);
                                chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                                chk("bus_idle_at_rsp",
                                    32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                                         bus.M_AXI_ARVALID, bus.M_AXI_RREADY}), 32'd0);
                                if (!e.tmo) begin
                                    chk("aw_handshakes", 32'(n_aw - e.aw0), e.wr ? 32'd1 : 32'd0);
                                    chk("w_handshakes", 32'(n_w - e.w0), e.wr ? 32'd1 : 32'd0);
                                    chk("b_handshakes", 32'(n_b - e.b0), e.wr ? 32'd1 : 32'd0);
                                    chk("bready_phases", 32'(n_brise - e.br0), e.wr ? 32'd1 : 32'd0);
                                    chk("ar_handshakes", 32'(n_ar - e.ar0), e.wr ? 32'd0 : 32'd1);
                                    chk("r_handshakes", 32'(n_r - e.r0), e.wr ? 32'd0 : 32'd1);
                                end
                            end
                            rsp_cnt++;
                            last_rsp_cyc = cyc;
                        end
                    end
                end
            end
            // stimulus
            begin
                int start;
                int i;
                tick(); tick();
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
                chk("rst_valids", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 32'd0);
                chk("rst_readies", 32'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'd0);
                chk("rst_awaddr", 32'(bus.M_AXI_AWADDR), 32'd0);
                chk("rst_wdata", bus.M_AXI_WDATA, 32'd0);
                chk("rst_rsp", 32'({rsp_valid, rsp_write, rsp_resp, rsp_timeout}), 32'd0);
                chk("rst_rdata", rsp_rdata, 32'd0);
                chk("prot", 32'({bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}), 32'd0);
                rst = 1'b0;
                tick();
                chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

                issue(1, 9'h000, 32'h0000_0003, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);
                issue(0, 9'h008, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'hDEAD_BEEF, 0, 0);
                issue(1, 9'h010, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);
                issue(1, 9'h014, 32'hA5A5_0F0F, 4'hC, 0, 3, 1, 0, 0, 2'b10, 32'h0, 0, 0);
                issue(1, 9'h018, 32'h0BAD_F00D, 4'hF, 0, 0, HANG, 0, 0, 2'b00, 32'h0, 0, 0);
                issue(0, 9'h01C, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b01, 32'h5555_AAAA, 0, 0);
                issue(0, 9'h020, 32'h0, 4'h0, 0, 0, 0, 1, HANG, 2'b00, 32'h1111_2222, 0, 0);
                issue(1, 9'h024, 32'h7777_8888, 4'h5, HANG, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);
                issue(0, 9'h030, 32'h0, 4'h0, 0, 0, 0, 1, 1, 2'b00, 32'hCAFE_0001, 1, 0);
                issue(0, 9'h034, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'hCAFE_0002, 0, 1);

                // reset in the middle of a read response wait
                cmd_write = 1'b0; cmd_addr = 9'h040; cmd_valid = 1'b1;
                i = 0;
                while (!cmd_ready && i < 40) begin i++; tick(); end
                if (!cmd_ready) fail_bound("rst_test_accept");
                d_ar = 0; d_r = HANG; cur_addr = 9'h040;
                tick();
                cmd_valid = 1'b0;
                tick(); tick();
                chk("rd_resp_rready", 32'(bus.M_AXI_RREADY), 32'd1);
                start = rsp_cnt;
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_arvalid", 32'(bus.M_AXI_ARVALID), 32'd0);
                chk("rst_mid_rready", 32'(bus.M_AXI_RREADY), 32'd0);
                chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
                tick(); tick();
                rst = 1'b0;
                tick();
                chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("post_rst_no_rsp", 32'(rsp_cnt - start), 32'd0);
                tick(); tick();
                chk("post_rst_no_rsp_late", 32'(rsp_cnt - start), 32'd0);

                for (int n = 0; n < 40; n++) begin
                    bit          wr;
                    logic [AW-1:0] a;
                    wr = 1'($urandom_range(0, 1));
                    a  = AW'($urandom_range(0, 511));
                    issue(wr, a, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          $urandom, 0, 0);
                end
                tick(); tick();
                chk("sb_drained", 32'(sb.size()), 32'd0);
            end
            // watchdog
            begin
                #200000;
                fail_bound("global_watchdog");
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
